// File: rtl/pic_priority_isr.sv
// 8259A request/priority/in-service stage: IRR capture, rotating priority vs ISR, INT and two-pulse INTA handshake.
// Latency: INT registered one clock after IRR shows a winner; INT_VEC final in ACK2. No backpressure (CPU paces INTA).
module pic_priority_isr #(
  parameter logic [2:0]  SPURIOUS_LEVEL = 3'd7,
  parameter int unsigned ACK_TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [7:0] IR,
  input  logic [7:0] IMR,
  input  logic       LTIM,
  input  logic       AEOI,
  input  logic [7:0] ocw2,
  input  logic       ocw2_wr,
  input  logic       INTA,
  output logic       INT,
  output logic [2:0] INT_VEC,
  output logic       vec_valid,
  output logic [7:0] IRR,
  output logic [7:0] ISR
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACK1, S_ACK2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         irr_q, irr_d;
  logic [7:0]         isr_q, isr_d;
  logic [7:0]         ir_q;
  logic               inta_q;
  logic [2:0]         lowest_q, lowest_d;
  logic               rot_aeoi_q, rot_aeoi_d;
  logic               int_q, int_d;
  logic [2:0]         vec_q, vec_d;
  logic               spur_q, spur_d;

  logic [7:0] req_m;
  logic [2:0] idx;
  logic       req_found, isr_found;
  logic [2:0] req_k, isr_k;
  logic       winner_vld;
  logic [2:0] win_lvl, isr_top;
  logic       fall;
  logic [7:0] ack_set, aeoi_clr, eoi_clr;
  logic       aeoi_rot, vv;
  logic       ptr_wr;
  logic [2:0] ptr_val;

  // Scan in priority order; k is the rank relative to (lowest + 1), smallest rank wins.
  always_comb begin
    req_m     = irr_q & ~IMR;
    idx       = '0;
    req_found = 1'b0;
    req_k     = '0;
    isr_found = 1'b0;
    isr_k     = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = lowest_q + 3'd1 + 3'(k);
      if (req_m[idx]) begin
        req_found = 1'b1;
        req_k     = 3'(k);
      end
      if (isr_q[idx]) begin
        isr_found = 1'b1;
        isr_k     = 3'(k);
      end
    end
  end

  assign winner_vld = req_found & (~isr_found | (req_k < isr_k));
  assign win_lvl    = lowest_q + 3'd1 + req_k;
  assign isr_top    = lowest_q + 3'd1 + isr_k;
  assign fall       = ~INTA & inta_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    spur_d   = spur_q;
    ack_set  = '0;
    aeoi_clr = '0;
    aeoi_rot = 1'b0;
    vv       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_ACK1;
          cnt_d   = '0;
          if (winner_vld) begin
            ack_set = 8'b1 << win_lvl;
            vec_d   = win_lvl;
            spur_d  = 1'b0;
          end else begin
            vec_d  = SPURIOUS_LEVEL;
            spur_d = 1'b1;
          end
        end
      end
      S_ACK1: begin
        if (fall) begin
          state_d = S_ACK2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (ACK_TIMEOUT != 0 && cnt_d == CNT_W'(ACK_TIMEOUT)) state_d = S_IDLE;
        end
      end
      S_ACK2: begin
        vv      = 1'b1;
        state_d = S_IDLE;
        // A spurious acknowledge never owned an ISR bit, so AEOI must not touch one.
        if (AEOI && !spur_q) begin
          aeoi_clr = 8'b1 << vec_q;
          aeoi_rot = rot_aeoi_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eoi_clr    = '0;
    ptr_wr     = 1'b0;
    ptr_val    = lowest_q;
    rot_aeoi_d = rot_aeoi_q;
    if (ocw2_wr) begin
      case (ocw2[7:5])
        3'b001: if (isr_found) eoi_clr = 8'b1 << isr_top;
        3'b011: eoi_clr = 8'b1 << ocw2[2:0];
        3'b101: begin
          if (isr_found) begin
            eoi_clr = 8'b1 << isr_top;
            ptr_wr  = 1'b1;
            ptr_val = isr_top;
          end
        end
        3'b111: begin
          eoi_clr = 8'b1 << ocw2[2:0];
          ptr_wr  = 1'b1;
          ptr_val = ocw2[2:0];
        end
        3'b110: begin
          ptr_wr  = 1'b1;
          ptr_val = ocw2[2:0];
        end
        3'b100: rot_aeoi_d = 1'b1;
        3'b000: rot_aeoi_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    lowest_d = ptr_wr ? ptr_val : (aeoi_rot ? vec_q : lowest_q);
    isr_d    = (isr_q & ~(eoi_clr | aeoi_clr)) | ack_set;
    // A fresh rise in the grant cycle re-arms the bit; a held-high line does not.
    irr_d    = LTIM ? (IR & ~ack_set) : (IR & ((IR & ~ir_q) | (irr_q & ~ack_set)));
    int_d    = (state_d == S_IDLE) & winner_vld;
  end

  always_ff @(posedge clk) begin
    if (reset || init) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      irr_q      <= '0;
      isr_q      <= '0;
      ir_q       <= '0;
      inta_q     <= 1'b1;
      lowest_q   <= 3'd7;
      rot_aeoi_q <= 1'b0;
      int_q      <= 1'b0;
      vec_q      <= '0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      ir_q       <= IR;
      inta_q     <= INTA;
      lowest_q   <= lowest_d;
      rot_aeoi_q <= rot_aeoi_d;
      int_q      <= int_d;
      vec_q      <= vec_d;
      spur_q     <= spur_d;
    end
  end

  assign INT       = int_q;
  assign INT_VEC   = vec_q;
  assign vec_valid = vv & ~(reset | init);
  assign IRR       = irr_q;
  assign ISR       = isr_q;

endmodule

// File: tb/tb_pic_priority_isr.sv
// Directed bench for pic_priority_isr; expected values are hand-computed per step.
module tb_pic_priority_isr;

  logic       clk = 1'b0;
  logic       reset, init, LTIM, AEOI, ocw2_wr, INTA;
  logic [7:0] IR, IMR, ocw2;
  logic       INT, vec_valid;
  logic [2:0] INT_VEC;
  logic [7:0] IRR, ISR;

  int checks = 0;
  int errors = 0;

  pic_priority_isr #(.SPURIOUS_LEVEL(3'd7), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .init(init), .IR(IR), .IMR(IMR), .LTIM(LTIM),
    .AEOI(AEOI), .ocw2(ocw2), .ocw2_wr(ocw2_wr), .INTA(INTA),
    .INT(INT), .INT_VEC(INT_VEC), .vec_valid(vec_valid), .IRR(IRR), .ISR(ISR)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ack_first();
    INTA = 1'b0;
    tick();
    INTA = 1'b1;
  endtask

  // Leaves the FSM in ACK2.
  task automatic ack_second();
    tick();
    INTA = 1'b0;
    tick();
    INTA = 1'b1;
  endtask

  task automatic ack_cycle();
    ack_first();
    ack_second();
    tick();
  endtask

  task automatic wr_ocw2(input logic [7:0] v);
    ocw2    = v;
    ocw2_wr = 1'b1;
    tick();
    ocw2_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; LTIM = 1'b0; AEOI = 1'b0; ocw2_wr = 1'b0;
    INTA = 1'b1; IR = 8'h00; IMR = 8'h00; ocw2 = 8'h00;
    tick(); tick();
    reset = 1'b0;
    chk("rst_int", INT, 8'h0);
    chk("rst_irr", IRR, 8'h00);
    chk("rst_isr", ISR, 8'h00);
    chk("rst_vec", INT_VEC, 8'h0);
    chk("rst_vv", vec_valid, 8'h0);

    // Edge-triggered IR3, full handshake, then non-specific EOI.
    IR = 8'h08;
    tick();
    chk("e_irr", IRR, 8'h08);
    chk("e_int_early", INT, 8'h0);
    tick();
    chk("e_int", INT, 8'h1);
    ack_first();
    chk("e_isr_ack1", ISR, 8'h08);
    chk("e_irr_ack1", IRR, 8'h00);
    chk("e_vec_ack1", INT_VEC, 8'h3);
    chk("e_int_ack1", INT, 8'h0);
    IR = 8'h00;
    ack_second();
    chk("e_vv", vec_valid, 8'h1);
    chk("e_vec", INT_VEC, 8'h3);
    tick();
    chk("e_vv_gone", vec_valid, 8'h0);
    chk("e_isr", ISR, 8'h08);
    wr_ocw2(8'h20);
    chk("e_eoi", ISR, 8'h00);

    // Fully nested rule and masking with ISR[2] in service.
    IR = 8'h04;
    tick(); tick();
    ack_cycle();
    IR = 8'h20;
    tick(); tick();
    chk("n_isr", ISR, 8'h04);
    chk("n_irr5", IRR, 8'h20);
    chk("n_int_low", INT, 8'h0);
    IR = 8'h22;
    tick(); tick();
    chk("n_int_hi", INT, 8'h1);
    IMR = 8'h02;
    tick();
    chk("n_masked", INT, 8'h0);
    IR = 8'h00; IMR = 8'h00;
    tick();
    wr_ocw2(8'h62);
    chk("n_seoi", ISR, 8'h00);

    // Set priority to lowest=4, IR0+IR6 -> 6, rotate-on-EOI -> IR7 highest.
    wr_ocw2(8'hC4);
    IR = 8'h41;
    tick(); tick();
    chk("r_int", INT, 8'h1);
    ack_cycle();
    chk("r_vec", INT_VEC, 8'h6);
    chk("r_isr", ISR, 8'h40);
    chk("r_irr", IRR, 8'h01);
    wr_ocw2(8'hA0);
    chk("r_isr_clr", ISR, 8'h00);
    IR = 8'hA1;
    tick(); tick();
    ack_cycle();
    chk("r_vec7", INT_VEC, 8'h7);
    chk("r_isr7", ISR, 8'h80);
    wr_ocw2(8'h20);
    IR = 8'h00;
    tick();
    wr_ocw2(8'hC7);
    chk("r_isr_end", ISR, 8'h00);

    // AEOI with rotation.
    AEOI = 1'b1;
    wr_ocw2(8'h80);
    IR = 8'h04;
    tick(); tick();
    ack_first();
    chk("a_vec", INT_VEC, 8'h2);
    chk("a_isr_ack1", ISR, 8'h04);
    ack_second();
    chk("a_vv", vec_valid, 8'h1);
    tick();
    chk("a_isr", ISR, 8'h00);
    IR = 8'h12;
    tick(); tick();
    ack_cycle();
    chk("a_rot_vec", INT_VEC, 8'h4);
    chk("a_isr2", ISR, 8'h00);
    AEOI = 1'b0;
    IR = 8'h00;
    wr_ocw2(8'h00);
    wr_ocw2(8'hC7);

    // Spurious: IR1 drops before ACK1 while ISR[3] is in service.
    IR = 8'h08;
    tick(); tick();
    ack_cycle();
    IR = 8'h02;
    tick(); tick();
    chk("s_int", INT, 8'h1);
    IR = 8'h00;
    tick(); tick();
    ack_first();
    chk("s_vec", INT_VEC, 8'h7);
    chk("s_isr", ISR, 8'h08);
    ack_second();
    chk("s_vv", vec_valid, 8'h1);
    tick();
    chk("s_isr_end", ISR, 8'h08);
    wr_ocw2(8'h20);
    chk("s_eoi", ISR, 8'h00);

    // Timeout after a lone first INTA; IR2 arriving in ACK1 raises INT only back in IDLE.
    ack_first();
    IR = 8'h04;
    tick(); tick(); tick();
    chk("t_int_held", INT, 8'h0);
    chk("t_vv0", vec_valid, 8'h0);
    tick();
    chk("t_int_idle", INT, 8'h1);
    chk("t_vv1", vec_valid, 8'h0);
    ack_first();
    chk("t_isr_grant", ISR, 8'h04);
    chk("t_vec_grant", INT_VEC, 8'h2);

    // Reset while in ACK1.
    reset = 1'b1; IR = 8'h00;
    tick();
    reset = 1'b0;
    chk("x_int", INT, 8'h0);
    chk("x_isr", ISR, 8'h00);
    chk("x_irr", IRR, 8'h00);
    chk("x_vec", INT_VEC, 8'h0);
    chk("x_vv", vec_valid, 8'h0);
    tick();
    chk("x_vv_after", vec_valid, 8'h0);

    // Held-high IR0: edge mode does not re-arm, level mode does; then init.
    IR = 8'h01;
    tick(); tick();
    ack_cycle();
    chk("l_isr", ISR, 8'h01);
    chk("l_edge_irr", IRR, 8'h00);
    LTIM = 1'b1;
    tick();
    chk("l_level_irr", IRR, 8'h01);
    init = 1'b1; IR = 8'h00; LTIM = 1'b0;
    tick();
    init = 1'b0;
    chk("i_isr", ISR, 8'h00);
    chk("i_irr", IRR, 8'h00);
    chk("i_vec", INT_VEC, 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_priority_isr.md
Name: pic_priority_isr

Overview:
- Interrupt request, priority resolution and in-service stage of the 8259A PIC.
- Sits directly downstream of ControlLogic and consumes its outputs:
  - IMR, LTIM and AEOI;
  - the OCW2 command byte;
  - an init strobe raised when ICW1 is received.
- Latches IR0–IR7 into IRR, resolves the highest-priority unmasked request against ISR, and drives INT.
- Runs the two-pulse INTA handshake and returns the 3-bit acknowledged level (INT_VEC) that ControlLogic merges with T7–T3.

Parameters:
- SPURIOUS_LEVEL, 3'd7: level returned when no valid request remains at the first INTA.
- ACK_TIMEOUT, 255: cycles allowed from ACK1 to the second INTA before the FSM aborts to IDLE; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  one-cycle pulse when ICW1 is received; same effect as reset.
- IR  in  8  interrupt request lines, already synchronous to clk.
- IMR  in  8  mask; 1 = level masked.
- LTIM  in  1  1 = level-triggered, 0 = edge-triggered.
- AEOI  in  1  automatic end of interrupt.
- ocw2  in  8  OCW2 byte: R = bit 7, SL = bit 6, EOI = bit 5, L2–L0 = bits 2:0.
- ocw2_wr  in  1  one-cycle strobe; ocw2 is valid in that cycle.
- INTA  in  1  active-low acknowledge from the CPU.
- INT  out  1  interrupt request to the CPU; registered.
- INT_VEC  out  3  acknowledged level.
- vec_valid  out  1  one-cycle pulse when INT_VEC is final.
- IRR  out  8  interrupt request register.
- ISR  out  8  in-service register.

Behaviour:
- Reset / init values:
  - IRR, ISR, INT_VEC, INT and vec_valid = 0.
  - Lowest-priority pointer lowest = 7, so IR0 has the highest priority.
  - rotate_aeoi = 0.
  - Both edge samplers: ir_q = 0, inta_q = 1.
  - FSM = IDLE; timeout counter = 0.
  - Reset or init asserted mid-handshake aborts the handshake: no ISR change, no vec_valid.
- Request capture, per bit i:
  - Edge mode: IRR[i] sets when IR[i] & ~ir_q[i].
  - Level mode: IRR[i] = IR[i].
  - In both modes IRR[i] clears when IR[i] = 0 at the sampling edge, so a request must stay high until ACK1.
  - IRR[i] clears on ACK1 when level i is granted.
  - Edge mode: a new rise in the same cycle as an ACK1 clear of the same bit re-sets IRR[i].
- Priority:
  - Order starts at level (lowest + 1) mod 8 and wraps.
  - A candidate is the highest-priority bit of IRR & ~IMR.
  - Fully nested rule: the candidate wins only if it is strictly higher in priority than the highest set ISR bit.
- INT:
  - Registered; asserts the cycle after a winner exists, so a clean edge shows INT two clocks after IR is first sampled high.
  - Held low from ACK1 until the FSM returns to IDLE.
- INTA edge detection: fall = ~INTA & inta_q.
- FSM:
  - IDLE, on fall:
    - If a winner exists: ISR[w] <= 1, IRR[w] <= 0, INT_VEC <= w.
    - Otherwise: INT_VEC <= SPURIOUS_LEVEL and ISR is left unchanged.
    - Go to ACK1 and clear the counter.
  - ACK1, on fall: go to ACK2.
  - ACK1, otherwise: increment the counter; if ACK_TIMEOUT != 0 and counter == ACK_TIMEOUT, go to IDLE.
  - ACK2, one cycle:
    - vec_valid = 1.
    - If AEOI, clear ISR[INT_VEC] (not for a spurious acknowledge); also set lowest <= INT_VEC if rotate_aeoi.
    - Go to IDLE.
- OCW2 decode on ocw2_wr, by {R, SL, EOI}:
  - 001, non-specific EOI: clear the highest-priority set ISR bit.
  - 011, specific EOI: clear ISR[L].
  - 101, rotate on non-specific EOI: clear the highest-priority set ISR bit h; lowest <= h.
  - 111, rotate on specific EOI: clear ISR[L]; lowest <= L.
  - 110, set priority: lowest <= L.
  - 100: rotate_aeoi <= 1.
  - 000: rotate_aeoi <= 0.
  - 010: no operation.
  - A non-specific EOI with ISR = 0 has no effect; for 101 lowest is also unchanged.
- Same-cycle events:
  - EOI decode uses the pre-edge ISR.
  - Next ISR = (ISR & ~eoi_clear) | ack_set, so a set wins on the same bit.
  - An OCW2 pointer write beats an AEOI rotate in the same cycle.

Test Plan:
- Edge basic: IMR = 0, LTIM = 0, pulse IR[3] -> INT = 1 two clocks later. Two INTA falls -> ISR = 8'h08, IRR = 0, INT_VEC = 3, vec_valid one cycle. Then OCW2 = 8'h20 -> ISR = 0.
- Nesting/mask: ISR[2] set, raise IR[5] -> INT stays 0. Raise IR[1] -> INT = 1. Set IMR[1] = 1 -> INT = 0.
- Rotation: OCW2 = 8'hC4 -> IR5 highest priority. Raise IR[0] and IR[6] together -> first ACK grants level 6. OCW2 = 8'hA0 -> ISR[6] cleared, lowest = 6, IR7 now highest priority.
- AEOI + rotate: AEOI = 1, OCW2 = 8'h80, ack IR[2] -> ISR = 0 after ACK2 and lowest = 2.
- Spurious: drop IR[4] after INT asserts, before ACK1 -> INT_VEC = 7, ISR unchanged.
- Timeout/reset: one INTA fall only, ACK_TIMEOUT = 4 -> FSM back in IDLE after 4 cycles, no vec_valid. Pulse reset in ACK1 -> all outputs 0.
